// File: rtl/sp_ram_pipe.sv
// Single-port RAM: valid/ready requests, byte enables, RD_LAT-deep read pipe, post-reset clear sweep.
// Define SP_RAM_PARITY_EN to add per-byte even parity storage and a parity_err response flag.
module sp_ram_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  parity_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    typedef enum logic [0:0] {StInit, StIdle} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                ready_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [RD_LAT-1:0]   pv_q;
    logic [DATA_W-1:0]   pd_q [RD_LAT];

    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                perr_q;

    logic                accept;
    logic                wr_en;
    logic                rd_en;
    logic                sweep_we;
    logic                par_mismatch;

    assign accept   = req_valid & ready_q;
    assign wr_en    = accept & req_we;
    assign rd_en    = accept & ~req_we;
    // Held reset must not disturb the array; the sweep only runs once reset is released.
    assign sweep_we = (state_q == StInit) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (&cnt_q) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                StIdle: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StInit;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
            end
        end
    end

    // Read data is sampled before any same-edge write lands, so write-then-read needs one cycle.
    always_ff @(posedge clk) begin
        pd_q[0] <= mem[req_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            pd_q[i] <= pd_q[i-1];
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] pp_q [RD_LAT];

    function automatic logic [NB-1:0] calc_par(input logic [DATA_W-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            par[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    par[req_addr][i] <= ^req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        pp_q[0] <= par[req_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            pp_q[i] <= pp_q[i-1];
        end
    end

    assign par_mismatch = |(calc_par(pd_q[RD_LAT-1]) ^ pp_q[RD_LAT-1]);
`else
    assign par_mismatch = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            perr_q      <= 1'b0;
        end else begin
            rsp_valid_q <= pv_q[RD_LAT-1];
            perr_q      <= pv_q[RD_LAT-1] & par_mismatch;
            if (pv_q[RD_LAT-1]) begin
                rsp_rdata_q <= pd_q[RD_LAT-1];
            end
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign parity_err = perr_q;

endmodule

// File: doc/sp_ram_pipe.md
# sp_ram_pipe

Parametrised single-port synchronous RAM with a valid/ready request port, per-byte write enables, a configurable read pipeline latency, and a post-reset hardware clear sweep. It is the next-generation replacement for the fixed 8-bit single-port RAM under the existing class-based bench. The bench's driver, monitor and reference model attach to it through an extended interface.

## Interface
Parameters:
- DATA_W, 8, word width in bits; must be a multiple of 8 (8..64)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- RD_LAT, 1, read latency in cycles from accept to response; legal range 1..4

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  read data valid, one-cycle pulse per accepted read
- rsp_rdata  out  DATA_W  read data
- parity_err  out  1  parity mismatch on the word in rsp_rdata (see Configuration)

## Operation
- Storage array is named mem, DEPTH x DATA_W; contents are not touched by reset itself.
- FSM states: INIT, IDLE.
  - reset asserted -> INIT, sweep counter = 0.
  - INIT: each cycle writes 0 (plus correct parity) to mem[counter] and increments the counter; req_ready = 0; after writing address DEPTH-1 -> IDLE.
  - IDLE: req_ready = 1 permanently; no other state exits IDLE except reset.
- Accept = req_valid & req_ready at a rising edge; one operation per cycle, no stall path.
- Write: for each i with req_be[i]=1, byte i of mem[req_addr] takes req_wdata byte i; bytes with be=0 keep their value. be=0 everywhere: accepted, no change. Writes produce no response.
- Read: mem[req_addr] is sampled at the accept edge and enters a RD_LAT-deep pipeline of {valid, data}. No response backpressure; back-to-back reads give back-to-back responses in order.
- Write to address A at edge N followed by read of A at edge N+1 returns the new data.
- Requests presented during INIT are ignored (not accepted, not queued).

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, parity_err=0, FSM=INIT, counter=0, read pipeline valid bits all 0.
- Reset mid-sweep restarts the sweep at address 0. Reset with reads in flight flushes them; no rsp_valid is ever produced for them.
- Sweep: the first rising edge after reset release writes address 0. Edge k writes address k-1. req_ready rises after edge DEPTH, so the first accept is possible at edge DEPTH+1.
- Read accepted at edge N: rsp_valid=1 and rsp_rdata valid during the cycle following edge N+RD_LAT, for exactly one cycle. rsp_rdata holds its last value while rsp_valid=0.
- Write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Throughput: one request per cycle in IDLE.

## Configuration
- SP_RAM_PARITY_EN defined:
  - A parallel array stores one even-parity bit per byte.
  - The parity bit is updated with its byte on writes and during the sweep.
  - On read, parity is recomputed from the read data and compared in the response stage.
  - parity_err = 1 in the same cycle as rsp_valid if any byte mismatches, and is 0 otherwise.
  - Data is returned unmodified regardless of the result.
- Not defined: no parity storage or logic; parity_err is tied to 0.

## Test plan
- Sweep check: reset 2 cycles then release, DEPTH=16. req_ready=0 for 16 edges and 1 from edge 17. Reads of all 16 addresses each return 0 with parity_err=0.
- Byte enables, DATA_W=32: write 0xAABBCCDD with be=4'b1111 to address 5, then write 0x11223344 with be=4'b0101. A read of address 5 returns 0xAA22CC44.
- Latency/throughput, RD_LAT=3: 8 back-to-back reads at edges N..N+7 give rsp_valid high for the 8 cycles after edges N+3..N+10, in order, with no gaps.
- Write-then-read: write 0x5A to address 3 at edge N, read address 3 at edge N+1, RD_LAT=1. The response after edge N+2 is 0x5A.
- Reset mid-operation: assert reset with 2 reads in flight and again at sweep address 7. No rsp_valid appears, all outputs return to reset values, and the sweep restarts at address 0, taking a full 16 cycles.
- Parity (macro defined): write 0x0F to address 2, then the bench deposits mem[2]=0x0E. A read of address 2 returns 0x0E with parity_err=1. A read of address 1 gives parity_err=0.
